// File: rtl/pwm_commit_scheduler.sv
// Shadows register-file writes and commits them to the PWM configuration outputs at
// period boundaries. Define PWM_RAMP_EN to ramp duties toward their targets by a step per period.
module pwm_commit_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             period_end,
  output logic [WIDTH-1:0] counter_value,
  output logic [WIDTH-1:0] prescaler,
  output logic [WIDTH-1:0] duty_cycle_1,
  output logic [WIDTH-1:0] duty_cycle_2,
  output logic [WIDTH-1:0] duty_cycle_3,
  output logic             enable_pwm,
  output logic             busy
);

`ifdef PWM_RAMP_EN
  typedef enum logic [1:0] {IDLE, ARMED, COMMIT, RAMP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sh_period;
  logic [WIDTH-1:0] sh_prescaler;
  logic [WIDTH-1:0] sh_target_1;
  logic [WIDTH-1:0] sh_target_2;
  logic [WIDTH-1:0] sh_target_3;
  logic             sh_enable;
`ifdef PWM_RAMP_EN
  logic [WIDTH-1:0] sh_step;
  logic             settled;
`endif
  logic             wr_fire;
  logic             wr_arms;
  logic [WIDTH-1:0] eff_1, eff_2, eff_3;
  logic [WIDTH-1:0] nxt_1, nxt_2, nxt_3;

  function automatic logic [WIDTH-1:0] clamp_target(input logic [WIDTH-1:0] target,
                                                    input logic [WIDTH-1:0] period);
    return (target > period) ? period : target;
  endfunction

`ifdef PWM_RAMP_EN
  // Difference is formed first so the move can never wrap or overshoot the target.
  function automatic logic [WIDTH-1:0] ramp_step(input logic [WIDTH-1:0] active,
                                                 input logic [WIDTH-1:0] target,
                                                 input logic [WIDTH-1:0] step);
    logic [WIDTH-1:0] diff;
    diff = (target >= active) ? (target - active) : (active - target);
    if ((step == '0) || (diff <= step)) return target;
    else if (target > active) return active + step;
    else return active - step;
  endfunction
`endif

  assign wr_fire = wr_valid && wr_ready;
`ifdef PWM_RAMP_EN
  assign wr_arms = wr_fire && (wr_addr != 3'd7);
`else
  assign wr_arms = wr_fire && (wr_addr != 3'd7) && (wr_addr != 3'd5);
`endif

  always_comb begin
    eff_1 = clamp_target(sh_target_1, sh_period);
    eff_2 = clamp_target(sh_target_2, sh_period);
    eff_3 = clamp_target(sh_target_3, sh_period);
`ifdef PWM_RAMP_EN
    nxt_1 = ramp_step(duty_cycle_1, eff_1, sh_step);
    nxt_2 = ramp_step(duty_cycle_2, eff_2, sh_step);
    nxt_3 = ramp_step(duty_cycle_3, eff_3, sh_step);
`else
    nxt_1 = eff_1;
    nxt_2 = eff_2;
    nxt_3 = eff_3;
`endif
  end

`ifdef PWM_RAMP_EN
  assign settled = (nxt_1 == eff_1) && (nxt_2 == eff_2) && (nxt_3 == eff_3);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      wr_ready      <= 1'b1;
      sh_period     <= '0;
      sh_prescaler  <= '0;
      sh_target_1   <= '0;
      sh_target_2   <= '0;
      sh_target_3   <= '0;
      sh_enable     <= 1'b0;
`ifdef PWM_RAMP_EN
      sh_step       <= WIDTH'(1);
`endif
      counter_value <= WIDTH'(255);
      prescaler     <= '0;
      duty_cycle_1  <= '0;
      duty_cycle_2  <= '0;
      duty_cycle_3  <= '0;
      enable_pwm    <= 1'b0;
    end else begin
      if (wr_fire) begin
        case (wr_addr)
          3'd0: sh_period    <= wr_data;
          3'd1: sh_prescaler <= wr_data;
          3'd2: sh_target_1  <= wr_data;
          3'd3: sh_target_2  <= wr_data;
          3'd4: sh_target_3  <= wr_data;
`ifdef PWM_RAMP_EN
          3'd5: sh_step      <= wr_data;
`endif
          3'd6: sh_enable    <= wr_data[0];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (wr_arms) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        // A disabled generator never wraps, so commit without waiting for a boundary.
        ARMED: begin
          if (period_end || !enable_pwm) begin
            state    <= COMMIT;
            wr_ready <= 1'b0;
          end
        end
        COMMIT: begin
          counter_value <= sh_period;
          prescaler     <= sh_prescaler;
          enable_pwm    <= sh_enable;
          duty_cycle_1  <= nxt_1;
          duty_cycle_2  <= nxt_2;
          duty_cycle_3  <= nxt_3;
          wr_ready      <= 1'b1;
`ifdef PWM_RAMP_EN
          if (settled) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RAMP;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
`ifdef PWM_RAMP_EN
        RAMP: begin
          if (period_end) begin
            state    <= COMMIT;
            wr_ready <= 1'b0;
          end else if (wr_arms) begin
            state <= ARMED;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/pwm_commit_scheduler.md
# pwm_commit_scheduler

Sequences configuration updates from the SPI register file into the three-channel PWM generator so that changes never corrupt a PWM period. Writes land in shadow registers; the block commits them to the PWM-facing outputs only at a period boundary, and can optionally ramp each duty cycle toward its target by a fixed step per period. It sits between the memory manager's write port and the PWM block's configuration inputs.

## Interface

Parameters:
- `WIDTH`, 32: width of period, prescaler, duty and step values.

Ports:
- `clk`  in  1: single system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_valid`  in  1: write request from the register file.
- `wr_ready`  out  1: write accepted on a cycle where `wr_valid` and `wr_ready` are both 1.
- `wr_addr`  in  3: 0 = period, 1 = prescaler, 2/3/4 = duty target ch1/ch2/ch3, 5 = ramp step, 6 = control (bit0 = enable), 7 = reserved.
- `wr_data`  in  WIDTH: write data.
- `period_end`  in  1: one-cycle pulse from the PWM block at counter wrap.
- `counter_value`  out  WIDTH: committed period.
- `prescaler`  out  WIDTH: committed prescaler.
- `duty_cycle_1`, `duty_cycle_2`, `duty_cycle_3`  out  WIDTH: active duty per channel.
- `enable_pwm`  out  1: committed enable.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation

- Shadow registers: period, prescaler, target[1..3], step, enable. An accepted write updates its shadow at the clock edge and sets `pending`. Address 7 is accepted and ignored, and does not set `pending`.
- Effective target: min(target[n], shadow period), using unsigned compare.
- States:
  - IDLE: nothing pending and all active duties equal their effective targets.
  - ARMED: `pending` set.
  - COMMIT: one cycle.
  - RAMP: no pending writes, but at least one duty is not yet at its target.
- Transitions:
  - IDLE → ARMED on an accepted write.
  - ARMED or RAMP → COMMIT on `period_end`.
  - ARMED → COMMIT immediately (next cycle) if `enable_pwm` is 0, because no boundary will arrive.
  - COMMIT → ARMED if a write arrived during COMMIT (impossible, see `wr_ready`), else → RAMP if any duty differs from its target, else → IDLE.
  - RAMP → ARMED on an accepted write. Ramping resumes at the following COMMIT.
- COMMIT action:
  - Copy period, prescaler and enable from shadow to outputs.
  - Clear `pending`.
  - For each channel, compute d = |eff_target − active|. If step = 0 or d ≤ step, active = eff_target. Otherwise active moves toward eff_target by step.
  - No wrap-around or overshoot is allowed. All arithmetic is WIDTH-bit unsigned, with the difference computed before the add/subtract.
- Channels ramp independently. A channel that reaches its target holds there while the others continue.
- Reset mid-operation: all state returns to reset values within one edge. Pending writes are discarded.

## Timing

- Reset values:
  - `counter_value` = 255, `prescaler` = 0, duties = 0, `enable_pwm` = 0.
  - Shadow step = 1, other shadows = 0.
  - State IDLE, `busy` = 0, `wr_ready` = 1.
- `wr_ready` = 0 only in the COMMIT cycle and is 1 in every other cycle, including during reset release.
- A write accepted in the same cycle as `period_end` is included in the commit that follows.
- Outputs change exactly one cycle after the `period_end` sample (the edge leaving COMMIT). They are registered and glitch-free.
- With enable 0: commit occurs two edges after the write edge (write → ARMED → COMMIT).
- `period_end` while in IDLE is ignored.

## Configuration

- `PWM_RAMP_EN` defined: ramp logic as described. The step register at address 5 is implemented and the RAMP state exists.
- `PWM_RAMP_EN` undefined:
  - Address 5 is accepted and ignored.
  - COMMIT sets every active duty to its effective target in one step.
  - RAMP state is absent, so COMMIT always goes to IDLE.

## Test plan

- Reset: assert `rst` for 2 cycles → `counter_value` = 255, duties = 0, `enable_pwm` = 0, `busy` = 0, `wr_ready` = 1.
- Disabled commit: write period = 1000, then control = 1 → outputs take period 1000 and enable 1 without any `period_end`; `busy` returns to 0.
- Boundary commit: with enable on, write duty1 = 400 and step = 0 → `duty_cycle_1` stays 0 until `period_end`, then is 400 one cycle later; `wr_ready` is 0 for exactly that cycle.
- Ramp (with `PWM_RAMP_EN`): step = 100, duty1 target = 350 from 0 → values 100, 200, 300, 350 on successive `period_end` pulses, with no overshoot; then IDLE.
- Clamp and down-ramp: period = 200, duty2 target = 500 → `duty_cycle_2` settles at 200. Then set target = 0 with step = 150 → 50, then 0.
- Simultaneous events and reset: write duty3 = 77 in the `period_end` cycle → committed next cycle. Assert `rst` during RAMP → all outputs return to reset values on the next edge.
